// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
// Pure declarations and helpers; no timing of its own.
// No flow control; consumers decide when these values are used.
package snake_pkg;

  // Default geometry and pacing; the top module exposes these as parameters.
  localparam int DEF_MAX_LEN  = 64;
  localparam int DEF_INIT_LEN = 4;
  localparam int DEF_MOVE_DIV = 12_500_000;

  // Width of the length register and of the RAM entry index.
  localparam int LEN_W = 11;

  // Every segment is plotted as a 4x4 block, so sub-square loops run 0..15.
  localparam logic [3:0] SUB_LAST = 4'd15;

  // Direction codes as seen by the datapath.
  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;

  // Controller states. CLR_START is the parking state held during reset,
  // where every strobe is low.
  typedef enum logic [4:0] {
    S_CLR_START,
    S_CLR_ADDR,
    S_CLR_RAM,
    S_INIT_ADDR,
    S_INIT_HEAD,
    S_INIT_Q,
    S_IDLE,
    S_WAIT,
    S_HEAD,
    S_CHECK,
    S_SH_WAIT,
    S_SH_CURR,
    S_SH_Q,
    S_SH_PREV,
    S_ERASE,
    S_DR_ADDR,
    S_DR_WAIT,
    S_DR_Q,
    S_DR_INC,
    S_FOOD,
    S_DEAD
  } state_t;

  // True when exactly one key bit is set.
  function automatic logic key_onehot(input logic [3:0] k);
    return (k == 4'b1000) || (k == 4'b0100) || (k == 4'b0010) || (k == 4'b0001);
  endfunction

  // Key order is {up, down, left, right}; only meaningful for one-hot keys.
  function automatic logic [2:0] key_to_dir(input logic [3:0] k);
    logic [2:0] d;
    d = DIR_UP;
    case (k)
      4'b1000: d = DIR_UP;
      4'b0100: d = DIR_DOWN;
      4'b0010: d = DIR_LEFT;
      4'b0001: d = DIR_RIGHT;
      default: d = DIR_UP;
    endcase
    return d;
  endfunction

  // A move straight back into the neck is never allowed.
  function automatic logic is_reverse(input logic [2:0] a, input logic [2:0] b);
    return ((a == DIR_UP)   && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN) && (b == DIR_UP))    ||
           ((a == DIR_LEFT) && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

endpackage

// File: rtl/snake_if.sv
// Control/status bundle between the snake controller and its datapath.
// Wires only; no latency.
// No backpressure; strobes are single-cycle commands the datapath must accept.
interface snake_if ();
  import snake_pkg::*;

  logic             start_key;
  logic [3:0]       key_dir;
  logic             isDead;
  logic             inc_length;

  logic [2:0]       dir;
  logic [3:0]       cnt_status;
  logic [LEN_W-1:0] length;

  logic lock;
  logic check_inc;
  logic ld_head;
  logic ld_q_def;
  logic inc_address;
  logic rst_address;
  logic draw_q;
  logic update_head;
  logic ld_head_into_prev;
  logic ld_q_into_curr;
  logic ld_prev_into_q;
  logic ld_curr_into_prev;
  logic draw_curr;
  logic food_en;
  logic reset_ram;

  // Controller side.
  modport master (
    input  start_key, key_dir, isDead, inc_length,
    output dir, cnt_status, length,
    output lock, check_inc, ld_head, ld_q_def, inc_address, rst_address,
    output draw_q, update_head, ld_head_into_prev, ld_q_into_curr,
    output ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, reset_ram
  );

  // Datapath side.
  modport slave (
    output start_key, key_dir, isDead, inc_length,
    input  dir, cnt_status, length,
    input  lock, check_inc, ld_head, ld_q_def, inc_address, rst_address,
    input  draw_q, update_head, ld_head_into_prev, ld_q_into_curr,
    input  ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, reset_ram
  );

endinterface

// File: rtl/snake_tick.sv
// Move-step divider: pulses tick on the last of MOVE_DIV enabled cycles.
// tick is combinational from the counter; the counter restarts when enable drops.
// No backpressure; enable low simply holds the counter at zero.
module snake_tick #(
  parameter int MOVE_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles; idle or terminal count returns to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/snake_control.sv
// Snake game sequencer: clears/initialises the segment RAM, then per move step
// shifts, erases, redraws and plots food. Moore strobes, one state per cycle.
// No backpressure; the datapath must act on every strobe in the cycle it is high.
module snake_control
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN,
  parameter int MOVE_DIV = DEF_MOVE_DIV
) (
  input logic     clk,
  input logic     rst,
  snake_if.master bus
);

  localparam logic [LEN_W-1:0] LAST_CLR  = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LAST_INIT = LEN_W'(INIT_LEN - 1);
  localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] INIT_L    = LEN_W'(INIT_LEN);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] length_r;
  logic [LEN_W-1:0] last_entry;
  logic [3:0]       sub;
  logic [2:0]       dir_r;
  logic             grow;
  logic             start_q;
  logic             start_edge;
  logic             move_en;
  logic             move_tick;
  logic             in_play;
  logic             sub_active;

  assign start_edge = bus.start_key && !start_q;
  assign last_entry = length_r - 1'b1;
  assign move_en    = (state == S_WAIT);
  assign in_play    = state inside {S_HEAD, S_CHECK, S_SH_WAIT, S_SH_CURR, S_SH_Q,
                                    S_SH_PREV, S_ERASE, S_DR_ADDR, S_DR_WAIT,
                                    S_DR_Q, S_DR_INC, S_FOOD};
  assign sub_active = state inside {S_ERASE, S_DR_Q, S_FOOD};

  snake_tick #(.MOVE_DIV(MOVE_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (move_en),
    .tick   (move_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CLR_START;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a dead report during a move step overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLR_START: state_nxt = S_CLR_ADDR;
      S_CLR_ADDR:  state_nxt = S_CLR_RAM;
      S_CLR_RAM:   if (idx == LAST_CLR) state_nxt = S_INIT_ADDR;
      S_INIT_ADDR: state_nxt = S_INIT_HEAD;
      S_INIT_HEAD: state_nxt = S_INIT_Q;
      S_INIT_Q:    if (idx == LAST_INIT) state_nxt = S_IDLE;
      S_IDLE:      if (start_edge) state_nxt = S_WAIT;
      S_WAIT:      if (move_tick) state_nxt = S_HEAD;
      S_HEAD:      state_nxt = S_CHECK;
      S_CHECK:     state_nxt = S_SH_WAIT;
      S_SH_WAIT:   state_nxt = S_SH_CURR;
      S_SH_CURR:   state_nxt = S_SH_Q;
      S_SH_Q:      state_nxt = S_SH_PREV;
      S_SH_PREV: begin
        if (idx == last_entry) state_nxt = grow ? S_DR_ADDR : S_ERASE;
        else                   state_nxt = S_SH_WAIT;
      end
      S_ERASE:     if (sub == SUB_LAST) state_nxt = S_DR_ADDR;
      S_DR_ADDR:   state_nxt = S_DR_WAIT;
      S_DR_WAIT:   state_nxt = S_DR_Q;
      S_DR_Q:      if (sub == SUB_LAST) state_nxt = S_DR_INC;
      S_DR_INC:    state_nxt = (idx == last_entry) ? S_FOOD : S_DR_WAIT;
      S_FOOD:      if (sub == SUB_LAST) state_nxt = S_WAIT;
      S_DEAD:      if (start_edge) state_nxt = S_CLR_ADDR;
      default:     state_nxt = S_CLR_START;
    endcase
    if (in_play && bus.isDead) state_nxt = S_DEAD;
  end

  // Moore strobe decode; the wait states (SH_WAIT, DR_WAIT) cover RAM read latency.
  always_comb begin
    bus.lock              = 1'b0;
    bus.check_inc         = 1'b0;
    bus.ld_head           = 1'b0;
    bus.ld_q_def          = 1'b0;
    bus.inc_address       = 1'b0;
    bus.rst_address       = 1'b0;
    bus.draw_q            = 1'b0;
    bus.update_head       = 1'b0;
    bus.ld_head_into_prev = 1'b0;
    bus.ld_q_into_curr    = 1'b0;
    bus.ld_prev_into_q    = 1'b0;
    bus.ld_curr_into_prev = 1'b0;
    bus.draw_curr         = 1'b0;
    bus.food_en           = 1'b0;
    bus.reset_ram         = 1'b0;
    case (state)
      S_CLR_ADDR:  bus.rst_address = 1'b1;
      S_CLR_RAM: begin
        bus.reset_ram   = 1'b1;
        bus.inc_address = 1'b1;
      end
      S_INIT_ADDR: bus.rst_address = 1'b1;
      S_INIT_HEAD: bus.ld_head     = 1'b1;
      S_INIT_Q: begin
        bus.ld_q_def    = 1'b1;
        bus.inc_address = 1'b1;
      end
      S_WAIT:      bus.lock = 1'b1;
      S_HEAD: begin
        bus.update_head       = 1'b1;
        bus.rst_address       = 1'b1;
        bus.ld_head_into_prev = 1'b1;
      end
      S_CHECK:     bus.check_inc      = 1'b1;
      S_SH_CURR:   bus.ld_q_into_curr = 1'b1;
      S_SH_Q:      bus.ld_prev_into_q = 1'b1;
      S_SH_PREV: begin
        bus.ld_curr_into_prev = 1'b1;
        bus.inc_address       = 1'b1;
      end
      S_ERASE:     bus.draw_curr   = 1'b1;
      S_DR_ADDR:   bus.rst_address = 1'b1;
      S_DR_Q:      bus.draw_q      = 1'b1;
      S_DR_INC:    bus.inc_address = 1'b1;
      S_FOOD:      bus.food_en     = 1'b1;
      default: ;
    endcase
  end

  // RAM entry index: cleared at the head of each sweep, stepped once per entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else begin
      case (state)
        S_CLR_ADDR, S_INIT_HEAD, S_HEAD, S_DR_ADDR: idx <= '0;
        S_CLR_RAM, S_INIT_Q, S_SH_PREV, S_DR_INC:   idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Sub-square counter for 4x4 plotting; parked at zero outside the plot loops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub <= '0;
    end else if (sub_active) begin
      sub <= sub + 1'b1;
    end else begin
      sub <= '0;
    end
  end

  // Length and grow flag; grow skips the tail erase for one step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      length_r <= '0;
      grow     <= 1'b0;
    end else begin
      case (state)
        S_CLR_ADDR: grow     <= 1'b0;
        S_INIT_Q:   length_r <= INIT_L;
        S_CHECK: begin
          if (bus.inc_length) begin
            grow <= 1'b1;
            if (length_r < MAX_L) length_r <= length_r + 1'b1;
          end
        end
        S_FOOD:     grow <= 1'b0;
        default: ;
      endcase
    end
  end

  // Direction latch: open only between moves, single-key and non-reversing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_r <= DIR_UP;
    end else if (state == S_INIT_Q) begin
      dir_r <= DIR_UP;
    end else if ((state == S_IDLE || state == S_WAIT) && key_onehot(bus.key_dir) &&
                 !is_reverse(dir_r, key_to_dir(bus.key_dir))) begin
      dir_r <= key_to_dir(bus.key_dir);
    end
  end

  // Start key edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= bus.start_key;
    end
  end

  assign bus.dir        = dir_r;
  assign bus.length     = length_r;
  assign bus.cnt_status = sub_active ? sub : 4'd0;

endmodule

// File: tb/tb_snake_control.sv
// Randomized bench for snake_control against a phase-level sequence model.
module tb_snake_control;

  localparam int MAX_LEN  = 8;
  localparam int INIT_LEN = 4;
  localparam int MOVE_DIV = 10;

  localparam logic [2:0] UP = 3'b100, DOWN = 3'b110, LEFT = 3'b000, RIGHT = 3'b001;

  // Observation vector: {cnt_status, 15 strobes}, bit positions below.
  localparam logic [18:0] M_LOCK  = 19'h00001, M_CHK   = 19'h00002, M_LDH   = 19'h00004;
  localparam logic [18:0] M_QDEF  = 19'h00008, M_INC   = 19'h00010, M_RSTA  = 19'h00020;
  localparam logic [18:0] M_DRAWQ = 19'h00040, M_UPD   = 19'h00080, M_HPREV = 19'h00100;
  localparam logic [18:0] M_QCURR = 19'h00200, M_PREVQ = 19'h00400, M_CPREV = 19'h00800;
  localparam logic [18:0] M_DCURR = 19'h01000, M_FOOD  = 19'h02000, M_RRAM  = 19'h04000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  snake_if sif ();

  snake_control #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .MOVE_DIV(MOVE_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ram_viol = 0;
  logic [18:0] cur;
  logic [18:0] exp_q[$];
  int mlen;
  logic [2:0] mdir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [18:0] snap();
    return {sif.cnt_status, sif.reset_ram, sif.food_en, sif.draw_curr, sif.ld_curr_into_prev,
            sif.ld_prev_into_q, sif.ld_q_into_curr, sif.ld_head_into_prev, sif.update_head,
            sif.draw_q, sif.rst_address, sif.inc_address, sif.ld_q_def, sif.ld_head,
            sif.check_inc, sif.lock};
  endfunction

  function automatic logic [18:0] with_cnt(input logic [18:0] m, input int k);
    return m | (19'(k) << 15);
  endfunction

  // One cycle: sample at the falling edge, track RAM write exclusivity.
  task automatic sample();
    @(negedge clk);
    cur = snap();
    if (int'(cur[14]) + int'(cur[3]) + int'(cur[10]) > 1) ram_viol++;
  endtask

  // Reference direction rule: single key only, never straight back.
  function automatic logic [2:0] want_dir(input logic [2:0] d, input logic [3:0] key);
    logic [2:0] nd;
    case (key)
      4'b1000: nd = UP;
      4'b0100: nd = DOWN;
      4'b0010: nd = LEFT;
      4'b0001: nd = RIGHT;
      default: return d;
    endcase
    if ((d == UP && nd == DOWN) || (d == DOWN && nd == UP) ||
        (d == LEFT && nd == RIGHT) || (d == RIGHT && nd == LEFT)) return d;
    return nd;
  endfunction

  task automatic build_clear_init();
    exp_q.delete();
    exp_q.push_back(M_RSTA);
    repeat (MAX_LEN) exp_q.push_back(M_RRAM | M_INC);
    exp_q.push_back(M_RSTA);
    exp_q.push_back(M_LDH);
    repeat (INIT_LEN) exp_q.push_back(M_QDEF | M_INC);
    exp_q.push_back(19'h0);
  endtask

  // Expected trace of one move step, from the HEAD cycle to the next WAIT cycle.
  task automatic build_step(input int len, input bit grow);
    exp_q.delete();
    exp_q.push_back(M_UPD | M_RSTA | M_HPREV);
    exp_q.push_back(M_CHK);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(19'h0);
      exp_q.push_back(M_QCURR);
      exp_q.push_back(M_PREVQ);
      exp_q.push_back(M_CPREV | M_INC);
    end
    if (!grow) for (int k = 0; k < 16; k++) exp_q.push_back(with_cnt(M_DCURR, k));
    exp_q.push_back(M_RSTA);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(19'h0);
      for (int k = 0; k < 16; k++) exp_q.push_back(with_cnt(M_DRAWQ, k));
      exp_q.push_back(M_INC);
    end
    for (int k = 0; k < 16; k++) exp_q.push_back(with_cnt(M_FOOD, k));
    exp_q.push_back(M_LOCK);
  endtask

  // Compare consecutive cycles (starting with cur) against exp_q; report first divergence.
  task automatic compare_seq(input string tag);
    int bad;
    logic [18:0] bad_got;
    bad = -1;
    bad_got = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) sample();
      if (bad < 0 && cur !== exp_q[i]) begin
        bad = i;
        bad_got = cur;
      end
    end
    if (bad >= 0) check($sformatf("%s[%0d]", tag, bad), 32'(bad_got), 32'(exp_q[bad]));
    else check(tag, 32'(cur), 32'(exp_q[exp_q.size()-1]));
  endtask

  task automatic check_clear_init(input string tag);
    int k;
    k = 0;
    while (!cur[5] && k < 8) begin
      sample();
      k++;
    end
    build_clear_init();
    compare_seq({tag, "_seq"});
    check({tag, "_len"}, 32'(sif.length), 32'(INIT_LEN));
    check({tag, "_dir"}, 32'(sif.dir), 32'(UP));
  endtask

  task automatic start_game();
    sif.start_key = 1'b1;
    sample();
    sif.start_key = 1'b0;
    mlen = INIT_LEN;
    mdir = UP;
  endtask

  // One move step starting from the first WAIT cycle.
  task automatic run_step(input logic [3:0] key, input bit inc);
    int n;
    sif.key_dir = key;
    sif.inc_length = inc;
    mdir = want_dir(mdir, key);
    n = 0;
    while (!cur[7] && n < MOVE_DIV + 5) begin
      if (cur[0]) n++;
      sample();
    end
    check("wait_len", 32'(n), 32'(MOVE_DIV));
    check("dir", 32'(sif.dir), 32'(mdir));
    if (inc && mlen < MAX_LEN) mlen++;
    build_step(mlen, inc);
    compare_seq("step");
    check("length", 32'(sif.length), 32'(mlen));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int q;
    logic [18:0] acc;
    sif.start_key = 1'b0;
    sif.key_dir = 4'b0;
    sif.isDead = 1'b0;
    sif.inc_length = 1'b0;
    #12;
    cur = snap();
    check("rst_outs", 32'(cur), 32'h0);
    check("rst_dir", 32'(sif.dir), 32'(UP));
    check("rst_len", 32'(sif.length), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    sample();
    check_clear_init("boot");

    // Directed direction cases first, then random keys and growth.
    start_game();
    for (int s = 0; s < 14; s++) begin
      logic [3:0] key;
      bit inc;
      case (s)
        0: key = 4'b0100;
        1: key = 4'b0010;
        2: key = 4'b1010;
        default: key = 4'($urandom_range(0, 15));
      endcase
      inc = (s < 3) ? (s == 2) : 1'($urandom_range(0, 1));
      run_step(key, inc);
    end

    // Death during DRAW, then restart.
    sif.key_dir = 4'b0;
    sif.inc_length = 1'b0;
    k = 0;
    while (!cur[6] && k < 400) begin
      sample();
      k++;
    end
    check("reach_draw", 32'(cur[6]), 32'h1);
    sif.isDead = 1'b1;
    sample();
    check("dead_now", 32'(cur), 32'h0);
    acc = '0;
    repeat (4) begin
      sample();
      acc |= cur;
    end
    check("dead_hold", 32'(acc), 32'h0);
    sif.isDead = 1'b0;
    sif.start_key = 1'b1;
    sample();
    sif.start_key = 1'b0;
    check_clear_init("restart");

    // Asynchronous reset in the second SHIFT entry.
    start_game();
    k = 0;
    q = 0;
    while (q < 2 && k < 200) begin
      sample();
      if (cur[9]) q++;
      k++;
    end
    check("reach_shift2", 32'(q), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    cur = snap();
    check("arst_outs", 32'(cur), 32'h0);
    check("arst_dir", 32'(sif.dir), 32'(UP));
    check("arst_len", 32'(sif.length), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sample();
    check_clear_init("post_rst");

    check("ram_excl", 32'(ram_viol), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
